// File: rtl/prod_accumulator.sv
// Accumulates ACC_LEN multiplier products into an OUT_W-bit sum using a valid/ready handshake on both sides.
// Define PROD_ACC_SAT_EN to saturate on overflow instead of wrapping.
module prod_accumulator #(
    parameter int ACC_LEN = 4,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  product,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       count,
    output logic             ovf
);
    localparam int         EW  = OUT_W + 1;
    localparam logic [4:0] LEN = 5'(ACC_LEN);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_nxt;
    logic [OUT_W-1:0] acc, acc_nxt;
    logic [4:0]       cnt, cnt_nxt;
    logic             ovf_r, ovf_nxt;
    logic             xfer;
    logic [OUT_W:0]   add_ext;
    logic             carry;

    assign in_ready  = (state != HOLD);
    assign xfer      = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign sum       = acc;
    assign count     = cnt;
    assign ovf       = ovf_r;

    // One extra bit so the carry-out of every addition is visible.
    assign add_ext = {1'b0, acc} + EW'(product);
    assign carry   = add_ext[OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf_r <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_r;
        case (state)
            IDLE: begin
                if (xfer) begin
                    acc_nxt   = OUT_W'(product);
                    cnt_nxt   = 5'd1;
                    ovf_nxt   = 1'b0;
                    state_nxt = (LEN == 5'd1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
`ifdef PROD_ACC_SAT_EN
                    acc_nxt = carry ? '1 : add_ext[OUT_W-1:0];
`else
                    acc_nxt = add_ext[OUT_W-1:0];
`endif
                    ovf_nxt = ovf_r | carry;
                    cnt_nxt = cnt + 5'd1;
                    if (cnt + 5'd1 == LEN)
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Result is held until the consumer takes it; inputs are stalled.
                if (out_ready) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 5'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: three instances (ACC_LEN 4, 8, 1) share one stimulus stream and are
// compared each cycle against a block-level arithmetic model, plus literal expectations.
module tb_prod_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] product;
    logic       in_valid;
    logic       out_ready;

    logic       ir_o  [3];
    logic [9:0] sum_o [3];
    logic       ov_o  [3];
    logic [4:0] cnt_o [3];
    logic       ovf_o [3];

    int  checks   = 0;
    int  failures = 0;
    bit  armed    = 0;

    int  len_m  [3] = '{4, 8, 1};
    int  cnt_m  [3];
    int  tot_m  [3];
    bit  hold_m [3];

    always #5 clk = ~clk;

    prod_accumulator #(.ACC_LEN(4), .IN_W(8), .OUT_W(10)) dut4 (
        .clk(clk), .rst(rst), .product(product), .in_valid(in_valid), .in_ready(ir_o[0]),
        .sum(sum_o[0]), .out_valid(ov_o[0]), .out_ready(out_ready), .count(cnt_o[0]), .ovf(ovf_o[0]));
    prod_accumulator #(.ACC_LEN(8), .IN_W(8), .OUT_W(10)) dut8 (
        .clk(clk), .rst(rst), .product(product), .in_valid(in_valid), .in_ready(ir_o[1]),
        .sum(sum_o[1]), .out_valid(ov_o[1]), .out_ready(out_ready), .count(cnt_o[1]), .ovf(ovf_o[1]));
    prod_accumulator #(.ACC_LEN(1), .IN_W(8), .OUT_W(10)) dut1 (
        .clk(clk), .rst(rst), .product(product), .in_valid(in_valid), .in_ready(ir_o[2]),
        .sum(sum_o[2]), .out_valid(ov_o[2]), .out_ready(out_ready), .count(cnt_o[2]), .ovf(ovf_o[2]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected visible sum from the true (unbounded) block total.
    function automatic int exp_sum(input int t);
`ifdef PROD_ACC_SAT_EN
        return (t > 1023) ? 1023 : t;
`else
        return t % 1024;
`endif
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                cnt_m[k] = 0; tot_m[k] = 0; hold_m[k] = 0;
            end else if (hold_m[k]) begin
                if (out_ready) begin hold_m[k] = 0; cnt_m[k] = 0; end
            end else if (in_valid) begin
                tot_m[k] = (cnt_m[k] == 0) ? int'(product) : tot_m[k] + int'(product);
                cnt_m[k]++;
                if (cnt_m[k] == len_m[k]) hold_m[k] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("u%0d.in_ready", k),  int'(ir_o[k]),  int'(!hold_m[k]));
                chk($sformatf("u%0d.out_valid", k), int'(ov_o[k]),  int'(hold_m[k]));
                chk($sformatf("u%0d.count", k),     int'(cnt_o[k]), cnt_m[k]);
                chk($sformatf("u%0d.sum", k),       int'(sum_o[k]), exp_sum(tot_m[k]));
                chk($sformatf("u%0d.ovf", k),       int'(ovf_o[k]), int'(tot_m[k] > 1023));
            end
        end
    end

    task automatic cyc(input bit iv, input int p, input bit ordy);
        in_valid = iv; product = 8'(p); out_ready = ordy;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(0, 0, 0); rst = 1'b0;
    endtask

    initial begin
        int seq [4];
        rst = 1'b1; in_valid = 0; product = 0; out_ready = 0;
        cyc(0, 0, 0); cyc(0, 0, 0);
        rst = 1'b0;
        armed = 1;
        chk("reset.out_valid", int'(ov_o[0]), 0);
        chk("reset.count", int'(cnt_o[0]), 0);
        chk("reset.sum", int'(sum_o[0]), 0);
        chk("reset.in_ready", int'(ir_o[0]), 1);

        // Basic sum, consumer always ready
        seq = '{6, 28, 120, 0};
        for (int i = 0; i < 4; i++) begin
            chk("sum.pre_valid", int'(ov_o[0]), 0);
            cyc(1, seq[i], 1);
        end
        chk("sum.valid", int'(ov_o[0]), 1);
        chk("sum.value", int'(sum_o[0]), 154);
        chk("sum.count", int'(cnt_o[0]), 4);
        chk("sum.ovf", int'(ovf_o[0]), 0);
        cyc(0, 0, 1);
        chk("sum.drop", int'(ov_o[0]), 0);

        // Backpressure
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, seq[i], 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp.sum", int'(sum_o[0]), 154);
            chk("bp.in_ready", int'(ir_o[0]), 0);
            chk("bp.count", int'(cnt_o[0]), 4);
            cyc(1, 99, 0);
        end
        cyc(0, 0, 1);
        chk("bp.release_valid", int'(ov_o[0]), 0);
        chk("bp.release_ready", int'(ir_o[0]), 1);

        // Overflow on the 8-deep instance
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 200, 0);
        chk("ovf.valid", int'(ov_o[1]), 1);
`ifdef PROD_ACC_SAT_EN
        chk("ovf.sum", int'(sum_o[1]), 1023);
`else
        chk("ovf.sum", int'(sum_o[1]), 576);
`endif
        chk("ovf.flag", int'(ovf_o[1]), 1);
        cyc(0, 0, 1);

        // Reset mid-block, with a simultaneous transfer that must lose to reset
        do_reset();
        cyc(1, 15, 1); cyc(1, 56, 1);
        rst = 1'b1; cyc(1, 77, 1); rst = 1'b0;
        chk("rstmid.count", int'(cnt_o[0]), 0);
        chk("rstmid.sum", int'(sum_o[0]), 0);
        chk("rstmid.valid", int'(ov_o[0]), 0);
        for (int i = 1; i <= 4; i++) cyc(1, i, 0);
        chk("rstmid.sum2", int'(sum_o[0]), 10);
        chk("rstmid.valid2", int'(ov_o[0]), 1);
        // Reset while holding discards the pending result
        rst = 1'b1; cyc(0, 0, 1); rst = 1'b0;
        chk("rsthold.valid", int'(ov_o[0]), 0);

        // Gapped single-product blocks
        for (int r = 0; r < 3; r++) begin
            cyc(1, 120, 1);
            chk("gap.valid", int'(ov_o[2]), 1);
            chk("gap.sum", int'(sum_o[2]), 120);
            chk("gap.count", int'(cnt_o[2]), 1);
            cyc(0, 0, 1);
            chk("gap.drop", int'(ov_o[2]), 0);
            cyc(0, 0, 1);
        end

        // Random-free mixed traffic to exercise out_ready ignored in IDLE/ACCUM
        for (int i = 0; i < 20; i++) cyc(i % 3 != 0, (i * 37) % 256, i % 4 == 1);

        @(negedge clk);
        armed = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter ACC_LEN, default 4, is the number of products summed per result; the legal range is 1..16.
REQ-002 Parameter IN_W, default 8, is the product width and matches the array multiplier Result output.
REQ-003 Parameter OUT_W, default 10, is the accumulator and sum width; OUT_W SHALL be >= IN_W.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  is the reset: synchronous, active-high.
REQ-006 product  input  IN_W  is the multiplier result to accumulate.
REQ-007 in_valid  input  1  means product is valid this cycle.
REQ-008 in_ready  output  1  means the block accepts product this cycle.
REQ-009 sum  output  OUT_W  is the accumulated result.
REQ-010 out_valid  output  1  means sum is valid.
REQ-011 out_ready  input  1  means the consumer takes sum this cycle.
REQ-012 count  output  5  is the number of products accepted in the current block.
REQ-013 ovf  output  1  is set when any addition in the current block exceeded OUT_W bits.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising clk edge.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD (combinational from state only).
REQ-017 IDLE plus a transfer: acc <= product, count <= 1, ovf <= 0; next state is HOLD if ACC_LEN==1, else ACCUM.
REQ-018 ACCUM plus a transfer: acc <= acc + product, count <= count + 1; go to HOLD when the new count equals ACC_LEN.
REQ-019 IDLE or ACCUM without a transfer: all state holds.
REQ-020 out_valid SHALL be 1 exactly while in HOLD, starting the cycle after the ACC_LEN-th transfer (latency 1).
REQ-021 sum SHALL be driven from acc and stay stable while out_valid=1.
REQ-022 HOLD with out_ready=1: next state is IDLE, count <= 0; out_valid falls the following cycle.
REQ-023 HOLD with out_ready=0: hold indefinitely; sum, count and ovf stay unchanged.
REQ-024 in_valid in HOLD SHALL be ignored (no transfer, no state change).
REQ-025 Addition SHALL be performed at OUT_W+1 bits; carry-out sets ovf (sticky until the next block starts).
REQ-026 out_ready in IDLE or ACCUM SHALL be ignored.

Reset
REQ-027 When rst=1 at a rising edge: state=IDLE, acc=0, count=0, ovf=0, out_valid=0.
REQ-028 A rst asserted mid-block (ACCUM or HOLD) SHALL discard the partial or pending result; no out_valid is produced for it.
REQ-029 rst SHALL take priority over every simultaneous transfer or out_ready.

Configuration
REQ-030 Macro PROD_ACC_SAT_EN: when defined, an overflowing addition loads acc with 2^OUT_W-1 and ovf=1.
REQ-031 Without PROD_ACC_SAT_EN: acc wraps modulo 2^OUT_W and ovf=1.
REQ-032 All other behaviour SHALL be identical with and without the macro.

Verification
REQ-033 Sum: ACC_LEN=4; products 6, 28, 120, 0 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the 4th; sum=154, count=4, ovf=0.
REQ-034 Backpressure: same as REQ-033 with out_ready=0 for 3 cycles -> sum=154 stable, in_ready=0, in_valid ignored; one cycle after out_ready=1, out_valid=0 and in_ready=1.
REQ-035 Overflow: ACC_LEN=8, OUT_W=10, eight products of 200 -> without the macro sum=576, ovf=1; with PROD_ACC_SAT_EN sum=1023, ovf=1.
REQ-036 Reset mid-block: ACC_LEN=4; accept 15, 56; assert rst one cycle -> count=0, sum=0, out_valid=0; next products 1, 2, 3, 4 -> sum=10.
REQ-037 Gapped input: ACC_LEN=1, product 120 with in_valid low between pulses -> each transfer gives out_valid next cycle with sum=120, count=1.
